// File: rtl/f_pc_ctrl_if.sv
// Fetch-control bus between hazard unit / D-stage resolver / fetch unit and f_pc_ctrl.
// The slave modport is the sequencer's view; the master modport is the surrounding pipeline.
interface f_pc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc;
  logic             stall_req;
  logic             br_valid;
  logic [31:0]      br_target;
  logic [31:0]      npc;
  logic             pc_wr_en;
  logic             pend_valid;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             adel;

  modport master (
    output pc, stall_req, br_valid, br_target,
    input  npc, pc_wr_en, pend_valid, fetch_cnt, stall_cnt, adel
  );

  modport slave (
    input  pc, stall_req, br_valid, br_target,
    output npc, pc_wr_en, pend_valid, fetch_cnt, stall_cnt, adel
  );
endinterface

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC sequencer: sequential fetch, redirects, stalls and a one-entry pending-redirect buffer.
// Optional redirect-target check enabled by defining F_PCCTRL_ALIGN_CHK_EN.
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter int          CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  f_pc_ctrl_if.slave bus
);

  // One past the last valid instruction address; 33 bits so the window top cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_p0, state_nxt;
  logic [31:0]      pend_target_p0;
  logic [CNT_W-1:0] fetch_cnt_p0, stall_cnt_p0;
  logic             adel_p0, adel_nxt;
  logic [31:0]      sel, npc_c;
  logic             wr_en, pend_load, redirect;

`ifdef F_PCCTRL_ALIGN_CHK_EN
  function automatic logic bad_target(input logic [31:0] t);
    return (t[1:0] != 2'b00) || (t < RESET_PC) || ({1'b0, t} >= IM_LIMIT);
  endfunction
`else
  logic unused_cfg;
  assign unused_cfg = ^{EXC_PC, IM_LIMIT};
`endif

  always_comb begin
    state_nxt = state_p0;
    pend_load = 1'b0;
    adel_nxt  = 1'b0;
    wr_en     = !bus.stall_req && !reset;
    redirect  = bus.br_valid || (state_p0 == HOLD);
    sel       = bus.pc + 32'd4;
    if (bus.br_valid)
      sel = bus.br_target;
    else if (state_p0 == HOLD)
      sel = pend_target_p0;

    case (state_p0)
      RUN: begin
        if (bus.stall_req && bus.br_valid) begin
          pend_load = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.stall_req)
          pend_load = bus.br_valid;
        else
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    npc_c = reset ? RESET_PC : sel;
`ifdef F_PCCTRL_ALIGN_CHK_EN
    // Only a redirect that is actually written is trapped; a buffered one is checked on release.
    if (wr_en && redirect && bad_target(sel)) begin
      npc_c    = EXC_PC;
      adel_nxt = 1'b1;
    end
`endif
  end

  // p0: sequencer state, pending redirect, counters, registered bad-fetch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0       <= RUN;
      pend_target_p0 <= 32'h0;
      fetch_cnt_p0   <= '0;
      stall_cnt_p0   <= '0;
      adel_p0        <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      if (pend_load)
        pend_target_p0 <= bus.br_target;
      fetch_cnt_p0 <= fetch_cnt_p0 + CNT_W'(wr_en);
      stall_cnt_p0 <= stall_cnt_p0 + CNT_W'(bus.stall_req);
      adel_p0      <= adel_nxt;
    end
  end

  logic unused_redirect;
  assign unused_redirect = redirect;

  assign bus.npc        = npc_c;
  assign bus.pc_wr_en   = wr_en;
  assign bus.pend_valid = (state_p0 == HOLD);
  assign bus.fetch_cnt  = fetch_cnt_p0;
  assign bus.stall_cnt  = stall_cnt_p0;
  assign bus.adel       = adel_p0;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: directed vectors, a cycle model and literal spot checks.
module tb_f_pc_ctrl;

`ifdef F_PCCTRL_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  f_pc_ctrl_if #(.CNT_W(32)) bus ();

  f_pc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Fetch-unit stand-in: PC register fed from npc, with an override for corner cases.
  logic [31:0] pcreg = 32'h3000;
  logic        ovr = 1'b0;
  logic [31:0] ovr_pc = 32'h0;
  assign bus.pc = ovr ? ovr_pc : pcreg;

  // Reference model state
  logic        started = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = 32'h0;
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_stall = 32'h0;
  logic        m_adel = 1'b0;
  logic [31:0] e_sel, e_npc;
  logic        e_wr, e_badwr;

  always_comb begin
    e_sel   = bus.pc + 32'd4;
    e_badwr = 1'b0;
    if (bus.br_valid)
      e_sel = bus.br_target;
    else if (m_pend)
      e_sel = m_tgt;
    e_wr = !reset && !bus.stall_req;
    if (ALN && e_wr && (bus.br_valid || m_pend))
      e_badwr = (e_sel % 4 != 0) || (e_sel < 32'h3000) || (e_sel >= 32'h3000 + 4 * 4096);
    e_npc = reset ? 32'h3000 : (e_badwr ? 32'h4180 : e_sel);
  end

  always @(posedge clk) begin
    if (reset) begin
      started <= 1'b1;
      m_pend  <= 1'b0;
      m_tgt   <= 32'h0;
      m_fetch <= 32'h0;
      m_stall <= 32'h0;
      m_adel  <= 1'b0;
      pcreg   <= 32'h3000;
    end else begin
      if (e_wr) begin
        m_fetch <= m_fetch + 32'd1;
        pcreg   <= bus.npc;
      end
      if (bus.stall_req)
        m_stall <= m_stall + 32'd1;
      m_adel <= e_badwr;
      if (bus.stall_req && bus.br_valid) begin
        m_pend <= 1'b1;
        m_tgt  <= bus.br_target;
      end else if (!bus.stall_req) begin
        m_pend <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_npc", bus.npc, e_npc);
      chk("m_wr", 32'(bus.pc_wr_en), 32'(e_wr));
      chk("m_pend", 32'(bus.pend_valid), 32'(m_pend));
      chk("m_fetch", bus.fetch_cnt, m_fetch);
      chk("m_stall", bus.stall_cnt, m_stall);
      chk("m_adel", 32'(bus.adel), 32'(m_adel));
    end
  end

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    reset         = r;
    bus.stall_req = s;
    bus.br_valid  = b;
    bus.br_target = t;
    @(negedge clk);
  endtask

  initial begin
    bus.stall_req = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = 32'h0;

    step(1, 0, 0, 0);
    chk("rst_npc", bus.npc, 32'h3000);
    chk("rst_wr", 32'(bus.pc_wr_en), 0);
    step(0, 0, 0, 0); chk("seq1", bus.npc, 32'h3004); chk("seq1_wr", 32'(bus.pc_wr_en), 1);
    step(0, 0, 0, 0); chk("seq2", bus.npc, 32'h3008);
    step(0, 0, 0, 0); chk("seq3", bus.npc, 32'h300C);
    step(0, 0, 0, 0); chk("seq4", bus.npc, 32'h3010);
    chk("fetch3", bus.fetch_cnt, 32'd3); chk("stall0", bus.stall_cnt, 32'd0);

    step(0, 0, 1, 32'h3040);
    chk("br_npc", bus.npc, 32'h3040); chk("br_pend", 32'(bus.pend_valid), 0);

    step(0, 1, 1, 32'h3080); chk("stl1_npc", bus.npc, 32'h3080); chk("stl1_wr", 32'(bus.pc_wr_en), 0);
    step(0, 1, 0, 0);        chk("stl2_pend", 32'(bus.pend_valid), 1); chk("stl2_npc", bus.npc, 32'h3080);
    step(0, 0, 0, 0);        chk("rel_npc", bus.npc, 32'h3080); chk("rel_wr", 32'(bus.pc_wr_en), 1);
    step(0, 0, 0, 0);        chk("rel_pend", 32'(bus.pend_valid), 0); chk("stall2", bus.stall_cnt, 32'd2);
    chk("after_rel", bus.npc, 32'h3084);

    step(0, 1, 1, 32'h3080);
    step(0, 1, 1, 32'h30C0); chk("newest_npc", bus.npc, 32'h30C0);
    step(0, 0, 0, 0);        chk("newest_rel", bus.npc, 32'h30C0);
    step(0, 0, 0, 0);        chk("newest_seq", bus.npc, 32'h30C4);

    step(0, 1, 1, 32'h3200);
    step(0, 0, 1, 32'h3100); chk("rel_br", bus.npc, 32'h3100);

    step(0, 1, 1, 32'h3300);
    step(1, 0, 0, 0);
    chk("rst_mid_npc", bus.npc, 32'h3000); chk("rst_mid_wr", 32'(bus.pc_wr_en), 0);
    step(0, 0, 0, 0);
    chk("rst_pend", 32'(bus.pend_valid), 0); chk("rst_fetch", bus.fetch_cnt, 0);
    chk("rst_stall", bus.stall_cnt, 0);

    step(0, 0, 1, 32'h3042); chk("mis_npc", bus.npc, ALN ? 32'h4180 : 32'h3042);
    step(0, 0, 0, 0);        chk("mis_adel", 32'(bus.adel), ALN ? 1 : 0);
    step(0, 0, 0, 0);        chk("mis_adel_clr", 32'(bus.adel), 0);
    step(0, 0, 1, 32'h2000); chk("low_npc", bus.npc, ALN ? 32'h4180 : 32'h2000);
    step(0, 0, 0, 0);        chk("low_adel", 32'(bus.adel), ALN ? 1 : 0);
    step(0, 1, 1, 32'h3042); chk("buf_npc", bus.npc, 32'h3042);
    step(0, 0, 0, 0);        chk("buf_adel", 32'(bus.adel), 0);
    chk("buf_rel", bus.npc, ALN ? 32'h4180 : 32'h3042);
    step(0, 0, 0, 0);        chk("buf_rel_adel", 32'(bus.adel), ALN ? 1 : 0);

    @(posedge clk);
    #1;
    ovr    = 1'b1;
    ovr_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_npc", bus.npc, 32'h0);
    @(posedge clk);
    #1;
    ovr = 1'b0;
    @(negedge clk);
    chk("wrap_next", bus.npc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
